// File: rtl/ahb_burst_arbiter_pkg.sv
// Shared AHB encodings and arbiter state type for the burst arbiter.
// Also holds the HBURST -> remaining-beat-count mapping used to lock fixed bursts.
package AHB_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_OWN   = 2'b01,
    ARB_BURST = 2'b10
  } arb_state_e;

  localparam int BEAT_W = 4;

  // Beats still to come after the NONSEQ; zero means the burst is not counted.
  function automatic logic [BEAT_W-1:0] burst_beats_m1(input hburst_e burst);
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats_m1 = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats_m1 = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_beats_m1 = 4'd15;
      default:                      burst_beats_m1 = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_prio_rr_picker.sv
// Combinational winner select: highest priority among requesters, ties broken
// round-robin by scanning upward from rr_ptr+1.
module ahb_prio_rr_picker
  import AHB_package::*;
#(
  parameter  int N_MASTER = 4,
  parameter  int PRIOR_W  = 2,
  localparam int IDX_W    = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic [N_MASTER-1:0]         hreq,
  input  logic [N_MASTER*PRIOR_W-1:0] hprior,
  input  logic [IDX_W-1:0]            rr_ptr,
  output logic                        valid,
  output logic [IDX_W-1:0]            winner_idx,
  output logic [N_MASTER-1:0]         winner_onehot
);

  logic [PRIOR_W-1:0] w_prio [N_MASTER];
  logic [PRIOR_W-1:0] w_best_prio;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W-1:0]   w_scan;

  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      w_prio[i] = hprior[i*PRIOR_W +: PRIOR_W];
    end
  end

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    valid         = 1'b0;
    winner_idx    = '0;
    winner_onehot = '0;
    w_best_prio   = '0;
    w_sum         = '0;
    w_scan        = '0;
    // Strict '>' keeps the earliest requester in scan order on a priority tie.
    for (int k = 1; k <= N_MASTER; k++) begin
      w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N_MASTER)) begin
        w_sum = w_sum - (IDX_W+1)'(N_MASTER);
      end
      w_scan = w_sum[IDX_W-1:0];
      if (hreq[w_scan] && (!valid || (w_prio[w_scan] > w_best_prio))) begin
        valid       = 1'b1;
        w_best_prio = w_prio[w_scan];
        winner_idx  = w_scan;
      end
    end
    if (valid) begin
      winner_onehot[winner_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_burst_arbiter.sv
// Per-slave AHB arbiter: priority grant with round-robin tie-break, grant held
// across fixed-length bursts and undefined-length INCR transfers.
module ahb_burst_arbiter
  import AHB_package::*;
#(
  parameter  int N_MASTER = 4,
  parameter  int PRIOR_W  = 2,
  localparam int IDX_W    = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic [N_MASTER-1:0]         hreq,
  input  logic [N_MASTER*PRIOR_W-1:0] hprior,
  input  logic [1:0]                  htrans,
  input  logic [2:0]                  hburst,
  input  logic                        hready,
  output logic [N_MASTER-1:0]         hgrant,
  output logic [IDX_W-1:0]            hmaster,
  output logic                        hsel
);

  arb_state_e          r_state,      w_state_nxt;
  logic [BEAT_W-1:0]   r_beat_cnt,   w_beat_nxt;
  logic [IDX_W-1:0]    r_rr_ptr,     w_rr_nxt;
  logic [N_MASTER-1:0] r_hgrant,     w_grant_nxt;
  logic [IDX_W-1:0]    r_hmaster,    w_master_nxt;

  logic                w_rearb;
  logic                w_valid;
  logic [IDX_W-1:0]    w_win_idx;
  logic [N_MASTER-1:0] w_win_onehot;
  htrans_e             w_trans;
  hburst_e             w_burst;

  assign w_trans = htrans_e'(htrans);
  assign w_burst = hburst_e'(hburst);

  ahb_prio_rr_picker #(
    .N_MASTER (N_MASTER),
    .PRIOR_W  (PRIOR_W)
  ) u_picker (
    .hreq          (hreq),
    .hprior        (hprior),
    .rr_ptr        (r_rr_ptr),
    .valid         (w_valid),
    .winner_idx    (w_win_idx),
    .winner_onehot (w_win_onehot)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat_cnt;
    w_rr_nxt     = r_rr_ptr;
    w_grant_nxt  = r_hgrant;
    w_master_nxt = r_hmaster;
    w_rearb      = 1'b0;

    case (r_state)
      ARB_OWN: begin
        if (hready) begin
          // A dropped owner request overrides whatever the owner is signalling.
          if (!hreq[r_hmaster]) begin
            w_rearb = 1'b1;
          end else begin
            case (w_trans)
              HTRANS_NONSEQ: begin
                if (burst_beats_m1(w_burst) != '0) begin
                  w_state_nxt = ARB_BURST;
                  w_beat_nxt  = burst_beats_m1(w_burst);
                end else if (w_burst == HBURST_SINGLE) begin
                  w_rearb = 1'b1;
                end
              end
              HTRANS_IDLE: w_rearb = 1'b1;
              default:     ;
            endcase
          end
        end
      end
      ARB_BURST: begin
        if (hready && (w_trans != HTRANS_BUSY)) begin
          if (w_trans == HTRANS_SEQ) begin
            if (r_beat_cnt > 4'd1) begin
              w_beat_nxt = r_beat_cnt - 4'd1;
            end else begin
              w_rearb = 1'b1;
            end
          end else begin
            w_rearb = 1'b1;
          end
        end
      end
      default: w_rearb = 1'b1;
    endcase

    if (w_rearb) begin
      if (w_valid) begin
        w_state_nxt  = ARB_OWN;
        w_grant_nxt  = w_win_onehot;
        w_master_nxt = w_win_idx;
        w_rr_nxt     = w_win_idx;
      end else begin
        w_state_nxt  = ARB_IDLE;
        w_grant_nxt  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state    <= ARB_IDLE;
      r_beat_cnt <= '0;
      r_rr_ptr   <= IDX_W'(N_MASTER - 1);
      r_hgrant   <= '0;
      r_hmaster  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_hgrant   <= w_grant_nxt;
      r_hmaster  <= w_master_nxt;
    end
  end

  assign hgrant  = r_hgrant;
  assign hmaster = r_hmaster;
  assign hsel    = (r_state != ARB_IDLE) & hreq[r_hmaster];

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Self-checking bench for ahb_burst_arbiter: directed scenarios plus a random
// run compared against an ownership/beats-left reference model.
module tb_ahb_burst_arbiter;

  localparam int N  = 4;
  localparam int PW = 2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_WRAP16 = 3'b110;

  logic          hclk;
  logic          hreset;
  logic [N-1:0]  hreq;
  logic [N*PW-1:0] hprior;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic          hready;
  logic [N-1:0]  hgrant;
  logic [1:0]    hmaster;
  logic          hsel;

  int n_checks;
  int n_pass;

  // Reference model: current owner (-1 = none), SEQ beats still owed, rr pointer.
  int m_owner;
  int m_left;
  int m_rr;
  int m_hm;

  ahb_burst_arbiter #(.N_MASTER(N), .PRIOR_W(PW)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .hreq    (hreq),
    .hprior  (hprior),
    .htrans  (htrans),
    .hburst  (hburst),
    .hready  (hready),
    .hgrant  (hgrant),
    .hmaster (hmaster),
    .hsel    (hsel)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  // Highest priority wins; ties go to the requester at the smallest distance past rr.
  function automatic int model_winner(input logic [N-1:0] req, input logic [N*PW-1:0] pr, input int rr);
    int best, bestp, bestd, p, d;
    best = -1; bestp = -1; bestd = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        p = int'(pr[i*PW +: PW]);
        d = (i - rr - 1 + N) % N;
        if (p > bestp || (p == bestp && d < bestd)) begin
          best = i; bestp = p; bestd = d;
        end
      end
    end
    return best;
  endfunction

  task automatic model_step();
    bit rearb;
    int w;
    rearb = 1'b0;
    if (hreset) begin
      m_owner = -1; m_left = 0; m_rr = N - 1; m_hm = 0;
      return;
    end
    if (m_owner < 0) begin
      rearb = 1'b1;
    end else if (m_left > 0) begin
      if (hready && htrans != T_BUSY) begin
        if (htrans == T_SEQ) begin
          m_left = m_left - 1;
          if (m_left == 0) rearb = 1'b1;
        end else begin
          rearb = 1'b1;
        end
      end
    end else if (hready) begin
      if (!hreq[m_owner]) rearb = 1'b1;
      else if (htrans == T_NONSEQ) begin
        if (int'(hburst) >= 2) m_left = (4 << ((int'(hburst) - 2) / 2)) - 1;
        else if (hburst == B_SINGLE) rearb = 1'b1;
      end else if (htrans == T_IDLE) rearb = 1'b1;
    end
    if (rearb) begin
      m_left = 0;
      w = model_winner(hreq, hprior, m_rr);
      if (w >= 0) begin
        m_owner = w; m_rr = w; m_hm = w;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b1; hreq = 4'b1111; hprior = '0;
    htrans = T_IDLE; hburst = B_SINGLE; hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (hgrant !== 4'b0000 || hsel !== 1'b0)
        $display("FAIL reset_hold cycle %0d hgrant=%b hsel=%b want 0000/0", i, hgrant, hsel);
      else n_pass++;
    end
    hreset = 1'b0;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hsel !== 1'b1)
      $display("FAIL reset_release hgrant=%b hmaster=%0d hsel=%b want 0001/0/1", hgrant, hmaster, hsel);
    else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    hreq = 4'b0110; hprior = {2'd2, 2'd3, 2'd0, 2'd0};
    tick();
    n_checks++;
    if (hgrant !== 4'b0100 || hmaster !== 2'd2)
      $display("FAIL priority hgrant=%b hmaster=%0d want 0100/2", hgrant, hmaster);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    hreq = 4'b1111; hprior = '0; htrans = T_NONSEQ; hburst = B_SINGLE; hready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = '0;
      exp[i % N] = 1'b1;
      n_checks++;
      if (hgrant !== exp)
        $display("FAIL round_robin step %0d hgrant=%b want %b", i, hgrant, exp);
      else n_pass++;
    end
  endtask

  task automatic test_incr8_lock();
    logic [1:0] tr [9] = '{T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_SEQ};
    logic       rd [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    hprior = {2'd3, 2'd0, 2'd1, 2'd0};
    hreq = 4'b0010; htrans = T_IDLE; hready = 1'b1;
    tick();
    hreq = 4'b1010; htrans = T_NONSEQ; hburst = B_INCR8;
    tick();
    n_checks++;
    if (hgrant !== 4'b0010)
      $display("FAIL incr8_start hgrant=%b want 0010", hgrant);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      htrans = tr[i]; hready = rd[i];
      tick();
      n_checks++;
      if (i < 8 && hgrant !== 4'b0010)
        $display("FAIL incr8_lock beat %0d hgrant=%b want 0010", i, hgrant);
      else if (i == 8 && (hgrant !== 4'b1000 || hmaster !== 2'd3))
        $display("FAIL incr8_handover hgrant=%b hmaster=%0d want 1000/3", hgrant, hmaster);
      else n_pass++;
    end
  endtask

  task automatic test_early_term();
    do_reset();
    hprior = '0; hreq = 4'b0011; htrans = T_IDLE; hready = 1'b1;
    tick();
    htrans = T_NONSEQ; hburst = B_WRAP16;
    tick();
    htrans = T_SEQ;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (hgrant !== 4'b0001)
      $display("FAIL early_term_locked hgrant=%b want 0001", hgrant);
    else n_pass++;
    htrans = T_IDLE;
    tick();
    n_checks++;
    if (hgrant !== 4'b0010 || hsel !== 1'b1)
      $display("FAIL early_term_rearb hgrant=%b hsel=%b want 0010/1", hgrant, hsel);
    else n_pass++;
    hreq = 4'b0001;
    #1;
    n_checks++;
    if (hsel !== 1'b0)
      $display("FAIL early_term_hsel hsel=%b want 0", hsel);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    hprior = '0; hreq = 4'b0100; htrans = T_IDLE; hready = 1'b1;
    tick();
    hreq = 4'b1111; htrans = T_NONSEQ; hburst = B_INCR4;
    tick();
    htrans = T_SEQ;
    tick();
    hreset = 1'b1;
    tick();
    n_checks++;
    if (hgrant !== 4'b0000 || hsel !== 1'b0 || hmaster !== 2'd0)
      $display("FAIL reset_mid_burst hgrant=%b hsel=%b hmaster=%0d want 0000/0/0", hgrant, hsel, hmaster);
    else n_pass++;
    hreset = 1'b0;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001)
      $display("FAIL reset_mid_burst_tie hgrant=%b want 0001", hgrant);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    logic         exp_s;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      hreset = ($urandom_range(0, 79) == 0);
      hreq   = N'($urandom_range(0, 15) | ($urandom_range(0, 3) == 0 ? 0 : (1 << $urandom_range(0, 3))));
      hprior = (N*PW)'($urandom);
      htrans = 2'($urandom_range(0, 3));
      hburst = 3'($urandom_range(0, 7));
      hready = ($urandom_range(0, 3) != 0);
      tick();
      exp_g = '0;
      if (m_owner >= 0) exp_g[m_owner] = 1'b1;
      exp_s = (m_owner >= 0) && hreq[m_hm];
      n_checks++;
      if (hgrant !== exp_g || hmaster !== 2'(m_hm) || hsel !== exp_s)
        $display("FAIL random cycle %0d hgrant=%b hmaster=%0d hsel=%b want %b/%0d/%b",
                 c, hgrant, hmaster, hsel, exp_g, m_hm, exp_s);
      else n_pass++;
    end
    hreset = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    m_owner = -1; m_left = 0; m_rr = N - 1; m_hm = 0;
    hreset = 1'b1; hreq = '0; hprior = '0; htrans = T_IDLE; hburst = B_SINGLE; hready = 1'b1;
    test_reset();
    test_priority();
    test_round_robin();
    test_incr8_lock();
    test_early_term();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
